dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single write port / single read port of the data memory between the pipeline MEM stage (CPU)
//  and a debug/loader requester (DBG). The CPU has priority. A starvation counter forces one DBG grant
//  after STARVE_MAX consecutive losses, and stalls the CPU for that cycle. Sits between EX_MEM outputs
//  and the DATAMEM instance; cpu_stall feeds the pipeline hazard/stall logic.
// PARAMETERS
//  ADDR_W      14  word-address width of data memory
//  DATA_W      32  data width
//  STARVE_MAX  8   consecutive DBG losses before a forced DBG grant; must be >=1
// PORTS
//  clk        in   1       system clock; all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  cpu_req    in   1       MEM stage needs memory this cycle (load or store)
//  cpu_we     in   1       store when 1, load when 0; ignored when cpu_req=0
//  cpu_addr   in   ADDR_W  word address
//  cpu_wdata  in   DATA_W  store data
//  cpu_rdata  out  DATA_W  load data (combinational from mem_rdata)
//  cpu_stall  out  1       CPU access not performed this cycle; pipeline must hold and re-present it
//  dbg_valid  in   1       DBG request; held stable until dbg_ready
//  dbg_we     in   1       DBG write when 1
//  dbg_addr   in   ADDR_W  DBG word address
//  dbg_wdata  in   DATA_W  DBG write data
//  dbg_ready  out  1       DBG request accepted this cycle (valid&ready = transfer)
//  dbg_rvalid out  1       1-cycle pulse: dbg_rdata holds data of the read accepted last cycle
//  dbg_rdata  out  DATA_W  registered DBG read data; held until the next accepted DBG read
//  mem_addr   out  ADDR_W  to DATAMEM a
//  mem_wdata  out  DATA_W  to DATAMEM d
//  mem_we     out  1       to DATAMEM we
//  mem_rdata  in   DATA_W  from DATAMEM spo (asynchronous read)
// BEHAVIOUR
//  - Grant is combinational per cycle: gnt_dbg = dbg_valid & (~cpu_req | force); gnt_cpu = cpu_req & ~gnt_dbg.
//  - force = (starve_cnt == STARVE_MAX). cpu_stall = cpu_req & gnt_dbg. dbg_ready = gnt_dbg.
//  - Mux: the granted side drives mem_addr/mem_wdata. mem_we = (gnt_cpu&cpu_we) | (gnt_dbg&dbg_we).
//    With no grant, mem_addr = cpu_addr and mem_we = 0.
//  - starve_cnt (0..STARVE_MAX): reset to 0 on gnt_dbg or ~dbg_valid; +1 when dbg_valid & cpu_req & ~gnt_dbg.
//    It never exceeds STARVE_MAX. A forced grant therefore happens at most once per STARVE_MAX+1 cycles.
//  - FSM (2 states): S_NORM -> S_FORCE when the counter reaches STARVE_MAX.
//    S_FORCE -> S_NORM after exactly one cycle (the forced grant). force is asserted only in S_FORCE.
//  - DBG read latency: 1 cycle. On an accepted read, dbg_rdata <= mem_rdata and the next cycle dbg_rvalid=1.
//    Back-to-back accepted reads give back-to-back rvalid pulses.
//  - One access per cycle, so a same-address CPU/DBG collision cannot race; the loser retries.
//  - Reset values: state=S_NORM, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0.
//    Combinational outputs follow their inputs.
//  - Reset mid-operation: a read in flight is dropped (no rvalid). The DBG side must re-issue it.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined: adds output perf_stall_cnt[31:0], which counts cycles with cpu_stall=1.
//    Cleared by rst, wraps at 2^32.
//  DMEM_ARB_PERF_EN undefined: port and counter absent; all other behaviour is identical.
// STRUCTURE
//  cpu_pkg: state encodings S_NORM/S_FORCE and the default ADDR_W/DATA_W localparams.
//  Sub-module dmem_starve_ctr: saturating counter plus the force flag, parameterised by STARVE_MAX.
// TESTING
//  1 Only DBG write addr=5, data=32'hDEAD_BEEF, cpu_req=0 -> dbg_ready=1 same cycle, mem_we=1.
//    Later DBG read addr=5 -> rvalid next cycle, dbg_rdata=32'hDEAD_BEEF.
//  2 cpu_req=1 load addr=3 with dbg_valid=0 -> cpu_rdata=mem[3], cpu_stall=0, mem_we=0.
//  3 cpu_req=1 held and dbg_valid=1 held, STARVE_MAX=8 -> dbg_ready=0 for 8 cycles.
//    Cycle 9: dbg_ready=1 and cpu_stall=1. Pattern repeats with period 9.
//  4 Same-cycle CPU store addr=7 =1 and DBG store addr=7 =2 -> CPU wins (mem[7]=1).
//    DBG completes later (mem[7]=2); no cycle has both writes.
//  5 Assert rst in the cycle after an accepted DBG read -> dbg_rvalid=0.
//    starve_cnt=0, state S_NORM, dbg_rdata=0 on the next cycle.
//  6 With DMEM_ARB_PERF_EN, scenario 3 for 27 cycles -> perf_stall_cnt=3.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg : shared encodings and default widths for the data-memory arbiter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic [0:0] S_NORM  = 1'b0;
  localparam logic [0:0] S_FORCE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_starve_ctr : DBG starvation counter and one-cycle forced-grant FSM    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_starve_ctr
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_valid,
  input  logic cpu_req,
  input  logic gnt_dbg,
  output logic force_gnt
);

  localparam int                CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic [0:0]       state;
  logic [0:0]       state_nxt;

  // The FSM tracks the counter so that S_FORCE coincides exactly with cnt==MAX.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (gnt_dbg || !dbg_valid) begin
      starve_cnt_nxt = '0;
    end else if (cpu_req && (starve_cnt != CNT_MAX)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
    state_nxt = (starve_cnt_nxt == CNT_MAX) ? S_FORCE : S_NORM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      state      <= S_NORM;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      state      <= state_nxt;
    end
  end

  assign force_gnt = (state == S_FORCE);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter : CPU-priority data-memory arbiter with DBG anti-starvation   |
// | Optional: DMEM_ARB_PERF_EN adds perf_stall_cnt (CPU stall cycle count)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic force_gnt;
  logic gnt_dbg;
  logic gnt_cpu;
  logic rvalid_q;

  dmem_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .dbg_valid (dbg_valid),
    .cpu_req   (cpu_req),
    .gnt_dbg   (gnt_dbg),
    .force_gnt (force_gnt)
  );

  assign gnt_dbg   = dbg_valid & (~cpu_req | force_gnt);
  assign gnt_cpu   = cpu_req & ~gnt_dbg;
  assign cpu_stall = cpu_req & gnt_dbg;
  assign dbg_ready = gnt_dbg;
  assign cpu_rdata = mem_rdata;

  // With no grant the CPU address is still presented so its read data stays live.
  assign mem_addr  = gnt_dbg ? dbg_addr  : cpu_addr;
  assign mem_wdata = gnt_dbg ? dbg_wdata : cpu_wdata;
  assign mem_we    = (gnt_cpu & cpu_we) | (gnt_dbg & dbg_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      rvalid_q <= gnt_dbg & ~dbg_we;
      if (gnt_dbg && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  // A read still in flight when reset arrives is dropped rather than reported.
  assign dbg_rvalid = rvalid_q & ~rst;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (cpu_stall) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
